// File: rtl/status_color_seq_pkg.sv
// Shared colour constants and state encoding for the status LED sequencer.
// Also reused by the RGB PWM stage and the board renderer.
package status_color_seq_pkg;

    localparam logic [2:0] C_OFF       = 3'b000;
    localparam logic [2:0] C_X         = 3'b100;
    localparam logic [2:0] C_O         = 3'b001;
    localparam logic [2:0] C_IDLE      = 3'b010;
    localparam logic [2:0] C_DRAW_HOLD = 3'b110;
    localparam logic [2:0] C_R         = 3'b100;
    localparam logic [2:0] C_G         = 3'b010;
    localparam logic [2:0] C_B         = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_WIN_FLASH,
        S_DRAW_ROT,
        S_WIN_HOLD,
        S_DRAW_HOLD
    } state_t;

    function automatic logic [2:0] side_color(input logic side);
        return side ? C_O : C_X;
    endfunction

    function automatic logic [2:0] rot_next(input logic [2:0] c);
        logic [2:0] n;
        n = C_R;
        case (c)
            C_R:     n = C_G;
            C_G:     n = C_B;
            default: n = C_R;
        endcase
        return n;
    endfunction

    function automatic logic is_anim(input state_t s);
        return (s == S_WIN_FLASH) || (s == S_DRAW_ROT);
    endfunction

endpackage

// File: rtl/status_tick.sv
// Animation prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap.
// A synchronous clear restarts the period so the first tick is TICK_DIV cycles out.
module status_tick #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = w_wrap && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/status_color_seq.sv
// Game-status colour sequencer: solid turn colour, win blink, draw rotation.
// Outputs are registered from the next-state decision, so events show 1 cycle later.
module status_color_seq
    import status_color_seq_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int FLASHES  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       player,
    input  logic       win,
    input  logic       winner,
    input  logic       draw,
    output logic [2:0] color,
    output logic       busy
);

    localparam int TW = $clog2(3 * FLASHES + 1);
    localparam logic [TW-1:0] WIN_TICKS  = TW'(2 * FLASHES);
    localparam logic [TW-1:0] DRAW_TICKS = TW'(3 * FLASHES);

    state_t        r_state;
    logic [TW-1:0] r_ticks;
    logic          r_winner;

    logic          w_tick;
    logic          w_clr;
    logic [TW-1:0] w_ticks_nxt;

    // The prescaler only runs inside an animation; held clear everywhere else
    assign w_clr       = new_game || !is_anim(r_state);
    assign w_ticks_nxt = r_ticks + 1'b1;

    status_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ticks  <= '0;
            r_winner <= 1'b0;
            color    <= C_OFF;
            busy     <= 1'b0;
        end else if (new_game) begin
            r_state <= S_TURN;
            r_ticks <= '0;
            color   <= side_color(player);
            busy    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    color <= C_IDLE;
                end
                S_TURN: begin
                    if (win) begin
                        r_state  <= S_WIN_FLASH;
                        r_winner <= winner;
                        r_ticks  <= '0;
                        color    <= side_color(winner);
                        busy     <= 1'b1;
                    end else if (draw) begin
                        r_state <= S_DRAW_ROT;
                        r_ticks <= '0;
                        color   <= C_R;
                        busy    <= 1'b1;
                    end else begin
                        color <= side_color(player);
                    end
                end
                S_WIN_FLASH: begin
                    if (w_tick) begin
                        r_ticks <= w_ticks_nxt;
                        if (w_ticks_nxt == WIN_TICKS) begin
                            r_state <= S_WIN_HOLD;
                            color   <= side_color(r_winner);
                            busy    <= 1'b0;
                        end else if (color == C_OFF) begin
                            color <= side_color(r_winner);
                        end else begin
                            color <= C_OFF;
                        end
                    end
                end
                S_DRAW_ROT: begin
                    if (w_tick) begin
                        r_ticks <= w_ticks_nxt;
                        if (w_ticks_nxt == DRAW_TICKS) begin
                            r_state <= S_DRAW_HOLD;
                            color   <= C_DRAW_HOLD;
                            busy    <= 1'b0;
                        end else begin
                            color <= rot_next(color);
                        end
                    end
                end
                S_WIN_HOLD: begin
                    color <= side_color(r_winner);
                    busy  <= 1'b0;
                end
                S_DRAW_HOLD: begin
                    color <= C_DRAW_HOLD;
                    busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    color   <= C_OFF;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_status_color_seq.sv
// Bench for status_color_seq: directed steps plus random events,
// checked against a time-since-entry reference model.
module tb_status_color_seq;

    localparam int TD = 4;
    localparam int FL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_game;
    logic       player;
    logic       win;
    logic       winner;
    logic       draw;
    logic [2:0] color;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    // Model: mode 0 idle, 1 turn, 2 win blink, 3 draw rotate, 4 win hold, 5 draw hold
    int         m_mode;
    int         m_el;
    logic [2:0] m_wcol;
    logic [2:0] m_color;
    logic       m_busy;
    logic [2:0] rot [3] = '{3'b100, 3'b010, 3'b001};

    status_color_seq #(
        .TICK_DIV(TD),
        .FLASHES (FL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .new_game(new_game),
        .player  (player),
        .win     (win),
        .winner  (winner),
        .draw    (draw),
        .color   (color),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_el    = 0;
        m_color = 3'b000;
        m_busy  = 1'b0;
    endtask

    task automatic model_step();
        int t;
        if (!rst) begin
            model_reset();
        end else begin
            if (new_game) begin
                m_mode = 1;
                m_el   = 0;
            end else begin
                case (m_mode)
                    1: begin
                        if (win) begin
                            m_mode = 2;
                            m_el   = 0;
                            m_wcol = winner ? 3'b001 : 3'b100;
                        end else if (draw) begin
                            m_mode = 3;
                            m_el   = 0;
                        end
                    end
                    2, 3: m_el++;
                    default: ;
                endcase
            end
            t = m_el / TD;
            case (m_mode)
                0: begin m_color = 3'b010; m_busy = 1'b0; end
                1: begin m_color = player ? 3'b001 : 3'b100; m_busy = 1'b0; end
                2: begin
                    if (t >= 2 * FL) begin
                        m_mode  = 4;
                        m_color = m_wcol;
                        m_busy  = 1'b0;
                    end else begin
                        m_color = (t % 2 == 0) ? m_wcol : 3'b000;
                        m_busy  = 1'b1;
                    end
                end
                3: begin
                    if (t >= 3 * FL) begin
                        m_mode  = 5;
                        m_color = 3'b110;
                        m_busy  = 1'b0;
                    end else begin
                        m_color = rot[t % 3];
                        m_busy  = 1'b1;
                    end
                end
                4: begin m_color = m_wcol; m_busy = 1'b0; end
                default: begin m_color = 3'b110; m_busy = 1'b0; end
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("color", color, m_color);
        chk("busy", {2'b00, busy}, {2'b00, m_busy});
        new_game = 1'b0;
        win      = 1'b0;
        draw     = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        new_game = 1'b0;
        player   = 1'b0;
        win      = 1'b0;
        winner   = 1'b0;
        draw     = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("reset_color", color, 3'b000);
        chk("reset_busy", {2'b00, busy}, 3'b000);
        cyc();
        cyc();
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("idle_color", color, 3'b010);

        // Turn colours follow player
        player = 1'b0; new_game = 1'b1; cyc();
        chk("turn_x", color, 3'b100);
        player = 1'b1; cyc();
        chk("turn_o", color, 3'b001);
        cyc();

        // Win by O, with stray win pulses during the blink
        win = 1'b1; winner = 1'b1; cyc();
        chk("win_entry", color, 3'b001);
        for (int i = 0; i < 22; i++) begin
            if ($urandom_range(3) == 0) begin
                win    = 1'b1;
                winner = 1'($urandom_range(1));
            end
            cyc();
        end
        chk("win_hold", color, 3'b001);

        // Draw rotation then yellow hold
        new_game = 1'b1; cyc();
        draw = 1'b1; cyc();
        repeat (28) cyc();
        chk("draw_hold", color, 3'b110);

        // Abort mid-blink, then a fresh full-length blink
        new_game = 1'b1; cyc();
        win = 1'b1; winner = 1'($urandom_range(1)); cyc();
        repeat (5) cyc();
        player = 1'b0; new_game = 1'b1; cyc();
        chk("abort_color", color, 3'b100);
        win = 1'b1; winner = 1'b0; cyc();
        repeat (20) cyc();

        // Coincident events
        new_game = 1'b1; cyc();
        player = 1'b1; win = 1'b1; draw = 1'b1; new_game = 1'b1; cyc();
        cyc();
        win = 1'b1; draw = 1'b1; winner = 1'b0; cyc();
        chk("win_over_draw", color, 3'b100);
        repeat (6) cyc();

        // Asynchronous reset mid-rotation
        new_game = 1'b1; cyc();
        draw = 1'b1; cyc();
        repeat (6) cyc();
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        #1;
        chk("async_color", color, m_color);
        chk("async_busy", {2'b00, busy}, {2'b00, m_busy});
        cyc();
        cyc();
        @(negedge clk);
        #2 rst = 1'b1;
        cyc();
        draw = 1'b1; cyc();
        draw = 1'b1; win = 1'b1; cyc();
        new_game = 1'b1; cyc();
        draw = 1'b1; cyc();
        repeat (26) cyc();

        // Random event soup
        for (int i = 0; i < 400; i++) begin
            new_game = ($urandom_range(31) == 0);
            win      = ($urandom_range(11) == 0);
            draw     = ($urandom_range(11) == 0);
            winner   = 1'($urandom_range(1));
            if ($urandom_range(5) == 0) player = ~player;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/status_color_seq.md
Name: status_color_seq

Overview:
Generates the 3-bit game-status colour consumed by the RGB PWM stage, which drives the board's status LED. It shows a solid colour for the player to move. On a win it blinks the winner's colour, then holds it solid. On a draw it rotates through R/G/B, then holds yellow. It sits between the game-control FSM (event pulses) and the RGB PWM stage (colour level).

Parameters:
TICK_DIV, 25000000, animation tick period in clk cycles (250 ms at 100 MHz); legal range ≥2.
FLASHES, 6, blink count on win; draw rotation lasts 3*FLASHES ticks; legal range ≥1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
new_game  input  1  one-cycle pulse: (re)start game display
player  input  1  side to move: 0 = X, 1 = O (level)
win  input  1  one-cycle pulse: game won
winner  input  1  winning side, sampled on the win cycle
draw  input  1  one-cycle pulse: game drawn
color  output  3  {R,G,B} colour level to the RGB PWM stage, registered
busy  output  1  high while a win/draw animation runs, registered

Behaviour:
- Colour constants: X = 3'b100 (red), O = 3'b001 (blue), IDLE = 3'b010 (green), DRAW_HOLD = 3'b110 (yellow), OFF = 3'b000.
- Reset (rst=0, asynchronous): state=IDLE, color=3'b000, busy=0, prescaler=0, tick/phase counters=0. The first registered edge after rst deasserts loads color=IDLE.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick on the cycle it wraps. Clears to 0 on every state entry, so the first tick comes exactly TICK_DIV cycles after entry.
- States and transitions:
  - IDLE: color=IDLE. new_game → TURN. win/draw are ignored.
  - TURN: color = player ? O : X; follows player with 1-cycle latency. win → WIN_FLASH. draw → DRAW_ROT.
  - WIN_FLASH: latch winner on entry. color=winner colour on the entry cycle+1. Each tick toggles color between the winner colour and OFF. After 2*FLASHES ticks → WIN_HOLD (solid winner colour). busy=1.
  - DRAW_ROT: color sequence R→G→B→R…, starting R on entry+1, advancing one step per tick. After 3*FLASHES ticks → DRAW_HOLD. busy=1.
  - WIN_HOLD / DRAW_HOLD: solid colour, busy=0. Only new_game leaves, → TURN.
- Latency: every input event is reflected on color/busy exactly 1 cycle later, because outputs are registered from next-state.
- Priority when events coincide: new_game > win > draw. new_game in any state, including mid-animation, aborts to TURN and clears the counters.
- win or draw pulses outside TURN are ignored. A second win during WIN_FLASH does not relatch winner.
- Tick counter width: $clog2(3*FLASHES+1). Prescaler width: $clog2(TICK_DIV). Neither counter ever wraps inside a state.
- Reset asserted mid-animation: outputs are immediately cleared (asynchronous) and the block returns to IDLE.

Decomposition:
- Shared package/header: the colour constants (X, O, IDLE, DRAW_HOLD, OFF, R, G, B) and the state encoding. The RGB PWM stage and the board renderer reuse the colour constants.
- One sub-module: status_tick. This is the prescaler with clk, rst (async active-low), clr (synchronous clear) and a 1-cycle tick output.

Test Plan:
(Bench uses TICK_DIV=4, FLASHES=2.)
1. Reset held low, then released: color=000 and busy=0 during reset; color=010 one cycle after release. Pulse new_game with player=0 → color=100 on the next cycle. Set player=1 → color=001 one cycle later.
2. In TURN, pulse win with winner=1 → busy=1 and color=001 next cycle. color toggles 001/000 every 4 cycles for 4 ticks, then stays 001 with busy=0. Extra win pulses have no effect.
3. In TURN, pulse draw → color sequence 100,010,001 repeated 2 times, each step 4 cycles long. Then color=110 and busy=0.
4. Mid WIN_FLASH (after 1 tick), pulse new_game with player=0 → color=100 and busy=0 next cycle. A later win starts a fresh full-length flash (first toggle exactly 4 cycles after entry).
5. In TURN, assert win, draw and new_game in the same cycle → TURN is kept (color follows player, busy=0). Assert win and draw together → WIN_FLASH is entered.
6. Assert rst low during DRAW_ROT, away from any clock edge → color=000 and busy=0 immediately. After release → color=010; draw pulses are ignored until new_game.
